// File: rtl/hadamard_fft_sched.sv
// Radix-4 DIF FFT sequencer driving a shared 4-point butterfly datapath over four banked sample RAMs.
// Optional watchdog on the datapath handshake: define HADAMARD_TIMEOUT_EN.
module hadamard_fft_sched #(
  parameter int FFT_N       = 256,
  parameter int TW_DEPTH    = 256,
  parameter int formatWidth = 9,
  parameter int ADDR_W      = 8,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fft_start,
  output logic                     fft_busy,
  output logic                     fft_done,
  output logic                     ram_rd_en,
  output logic [4*ADDR_W-1:0]      ram_addr,
  input  logic [4*formatWidth-1:0] ram_rd_real,
  input  logic [4*formatWidth-1:0] ram_rd_imag,
  output logic                     ram_wr_en,
  output logic [4*formatWidth-1:0] ram_wr_real,
  output logic [4*formatWidth-1:0] ram_wr_imag,
  output logic [4*ADDR_W-1:0]      tw_addr,
  output logic                     dp_start,
  output logic [4*formatWidth-1:0] dp_in_real,
  output logic [4*formatWidth-1:0] dp_in_imag,
  input  logic [4*formatWidth-1:0] dp_out_real,
  input  logic [4*formatWidth-1:0] dp_out_imag,
  input  logic                     dp_done,
  output logic                     err_timeout
);
  localparam int LOG2N = $clog2(FFT_N);
  localparam int NSTG  = LOG2N / 2;
  localparam int NB_W  = LOG2N - 2;
  localparam int S_W   = (NSTG > 1) ? $clog2(NSTG) : 1;
  localparam int TW_SH = $clog2(TW_DEPTH / FFT_N);
  localparam logic [NB_W-1:0] N_LAST = NB_W'(FFT_N / 4 - 1);
  localparam logic [S_W-1:0]  S_LAST = S_W'(NSTG - 1);

  if (FFT_N < 16 || (LOG2N % 2) != 0 || (1 << LOG2N) != FFT_N ||
      TW_DEPTH < FFT_N || (1 << $clog2(TW_DEPTH)) != TW_DEPTH || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("hadamard_fft_sched: illegal parameter set");
  end

  typedef enum logic [2:0] {IDLE, RD, LAT, GO, WAIT, WR, NEXT, DONE} state_t;
  state_t state, state_nxt;

  logic [NB_W-1:0] bfly, bfly_nxt, bfly_ld;
  logic [S_W-1:0]  stage, stage_nxt, stage_ld;
  logic            last_bfly, timeout_hit;

  // Leg m sits span apart inside a group of 4*span; span = 2^lspan.
  function automatic logic [4*ADDR_W-1:0] ram_addr_of(input int s, input int n);
    int lspan, base;
    lspan = LOG2N - 2 * (s + 1);
    base  = ((n >> lspan) << (lspan + 2)) + (n & ((1 << lspan) - 1));
    for (int m = 0; m < 4; m++) ram_addr_of[m*ADDR_W +: ADDR_W] = ADDR_W'(base + (m << lspan));
  endfunction

  // Twiddle index m*k*4^s scaled to the ROM depth, wrapped modulo TW_DEPTH.
  function automatic logic [4*ADDR_W-1:0] tw_addr_of(input int s, input int n);
    int lspan, k;
    lspan = LOG2N - 2 * (s + 1);
    k     = n & ((1 << lspan) - 1);
    for (int m = 0; m < 4; m++)
      tw_addr_of[m*ADDR_W +: ADDR_W] = ADDR_W'(((m * k) << (2 * s + TW_SH)) & (TW_DEPTH - 1));
  endfunction

  always_comb begin
    bfly_nxt  = bfly + 1'b1;
    stage_nxt = stage;
    if (bfly == N_LAST) begin
      bfly_nxt  = '0;
      stage_nxt = stage + 1'b1;
    end
    bfly_ld   = (state == IDLE) ? '0 : bfly_nxt;
    stage_ld  = (state == IDLE) ? '0 : stage_nxt;
    last_bfly = (bfly == N_LAST) && (stage == S_LAST);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fft_start) state_nxt = RD;
      RD:      state_nxt = LAT;
      LAT:     state_nxt = GO;
      GO:      state_nxt = WAIT;
      WAIT:    if (dp_done) state_nxt = WR;
               else if (timeout_hit) state_nxt = DONE;
      WR:      state_nxt = NEXT;
      NEXT:    state_nxt = last_bfly ? DONE : RD;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    fft_busy  = (state != IDLE);
    ram_rd_en = (state == RD);
    dp_start  = (state == GO);
    ram_wr_en = (state == WR);
    fft_done  = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bfly        <= '0;
      stage       <= '0;
      ram_addr    <= '0;
      tw_addr     <= '0;
      dp_in_real  <= '0;
      dp_in_imag  <= '0;
      ram_wr_real <= '0;
      ram_wr_imag <= '0;
    end else begin
      if (state == IDLE && fft_start) begin
        bfly  <= '0;
        stage <= '0;
      end else if (state == NEXT) begin
        bfly  <= bfly_nxt;
        stage <= stage_nxt;
      end
      // Address stage: loaded on entry to RD, held through WR of the same butterfly.
      if (state_nxt == RD) begin
        ram_addr <= ram_addr_of(int'(stage_ld), int'(bfly_ld));
        tw_addr  <= tw_addr_of(int'(stage_ld), int'(bfly_ld));
      end
      // Operand stage: RAM data arrives the cycle after the read strobe.
      if (state == LAT) begin
        dp_in_real <= ram_rd_real;
        dp_in_imag <= ram_rd_imag;
      end
      // Result stage
      if (state == WAIT && dp_done) begin
        ram_wr_real <= dp_out_real;
        ram_wr_imag <= dp_out_imag;
      end
    end
  end

`ifdef HADAMARD_TIMEOUT_EN
  localparam int WC_W = $clog2(TIMEOUT_CYC + 1);
  logic [WC_W-1:0] wait_cnt;
  logic            err_q;

  assign timeout_hit = (state == WAIT) && !dp_done && (wait_cnt == WC_W'(TIMEOUT_CYC - 1));
  assign err_timeout = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if ((state == IDLE && fft_start) || state == GO) wait_cnt <= '0;
      else if (state == WAIT)                          wait_cnt <= wait_cnt + 1'b1;
      if (timeout_hit) err_q <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err_timeout = 1'b0;
`endif

endmodule

// File: doc/hadamard_fft_sched.md
Name: hadamard_fft_sched

Overview:
- Sequencer for an in-place radix-4 DIF FFT built around the shared complexhadamard 4-point butterfly datapath.
- Per butterfly, it:
  - generates four banked sample-RAM addresses and reads the operands;
  - generates four twiddle-ROM addresses;
  - pulses the datapath start and waits for its done;
  - writes the four results back to the same addresses.
- Iterates over all butterflies of all log4(FFT_N) stages, then reports completion.

Parameters:
- FFT_N, 256, transform length; power of 4, minimum 16.
- TW_DEPTH, 256, twiddle ROM depth; must be ≥ FFT_N and a power of 2.
- formatWidth, 9, sample word width (1-4-4 float).
- ADDR_W, 8, sample and twiddle address width; log2(max(FFT_N, TW_DEPTH)).
- TIMEOUT_CYC, 64, watchdog limit in cycles (used only with the optional feature).

Ports:
- clk, in, 1, clock, rising edge.
- rst, in, 1, asynchronous active-low reset.
- fft_start, in, 1, start request; sampled only in IDLE.
- fft_busy, out, 1, high whenever state ≠ IDLE.
- fft_done, out, 1, one-cycle pulse when the transform completes.
- ram_rd_en, out, 1, read strobe to the four banks.
- ram_addr, out, 4*ADDR_W, leg m address at bits [m*ADDR_W +: ADDR_W]; shared by read and write.
- ram_rd_real / ram_rd_imag, in, 4*formatWidth each, read data, valid 1 cycle after ram_rd_en.
- ram_wr_en, out, 1, write strobe.
- ram_wr_real / ram_wr_imag, out, 4*formatWidth each, write data.
- tw_addr, out, 4*ADDR_W, twiddle ROM addresses; ROM data valid 1 cycle later and routed directly to the datapath.
- dp_start, out, 1, one-cycle start pulse to the datapath.
- dp_in_real / dp_in_imag, out, 4*formatWidth each, registered operands.
- dp_out_real / dp_out_imag, in, 4*formatWidth each, datapath results.
- dp_done, in, 1, datapath completion.
- err_timeout, out, 1, sticky watchdog flag (tied 0 when the feature is off).

Behaviour:
- Reset (rst=0, asynchronous):
  - state → IDLE; all counters and data registers → 0.
  - All outputs → 0, including fft_busy, strobes, addresses, err_timeout.
  - Reset mid-transform aborts with no further RAM writes.
- Counters:
  - stage s runs 0..S-1, where S = log4(FFT_N).
  - butterfly n runs 0..FFT_N/4-1.
  - span = FFT_N >> (2*(s+1)); g = n >> log2(span); k = n & (span-1).
- Addresses:
  - base = g*4*span + k.
  - ram_addr leg m = base + m*span, for m = 0..3.
  - tw_addr leg m = (m*k*4^s * (TW_DEPTH/FFT_N)) mod TW_DEPTH; leg 0 is always 0.
  - All address arithmetic is unsigned and truncated to ADDR_W.
- State machine:
  - IDLE: if fft_start → RD.
  - RD: ram_rd_en=1; ram_addr and tw_addr driven; → LAT.
  - LAT: capture ram_rd_* into dp_in_*; tw_addr held; → GO.
  - GO: dp_start=1 for exactly one cycle; → WAIT.
  - WAIT: hold dp_in_* and tw_addr. On dp_done=1, latch dp_out_* into ram_wr_* → WR.
  - WR: ram_wr_en=1 with the RD-cycle ram_addr; → NEXT.
  - NEXT: advance counters.
    - If n = FFT_N/4-1: n → 0 and s → s+1.
    - If s = S-1 as well → DONE; otherwise → RD.
  - DONE: fft_done=1 for one cycle; → IDLE.
- Handshake rules:
  - fft_start is ignored while busy.
  - dp_done outside WAIT is ignored.
  - dp_done is sampled in WAIT even when it arrives in the first WAIT cycle.
- Timing:
  - Per-butterfly period = 5 + W cycles, where W is the number of WAIT cycles, W ≥ 1.
  - Total butterflies = S * FFT_N/4.
- Outputs ram_addr, tw_addr, dp_in_*, ram_wr_* are registered and hold their last value when unused.

Optional Feature:
- Macro: HADAMARD_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYC without dp_done: set err_timeout (sticky until reset), pulse fft_done, → IDLE, no write.
  - The next fft_start clears the counters but not err_timeout.
- Undefined: no counter; WAIT is unbounded; err_timeout tied 0.

Test Plan:
- Reset and idle: rst=0 mid-WAIT with FFT_N=16 → next cycle all outputs 0, state IDLE, no ram_wr_en afterwards.
- Stage-0 addressing: FFT_N=16, TW_DEPTH=256, mock dp_done 2 cycles after dp_start.
  - n=0 → ram_addr {0,4,8,12}, tw_addr {0,0,0,0}.
  - n=1 → ram_addr {1,5,9,13}, tw_addr {0,16,32,48}.
- Stage-1 addressing: FFT_N=16.
  - n=2 → ram_addr {8,9,10,11}, tw_addr {0,0,0,0}.
  - Eight butterflies total; fft_done pulses 56 cycles after the first RD.
- Data path: RAM model returns real leg values {0x1C8,0x088,0x17F,0x1C8}; mock dp_out = dp_in inverted → ram_wr_real = {0x037,0x177,0x080,0x037} at the same addresses in WR.
- Start while busy plus stray dp_done: fft_start and dp_done pulsed during RD → no restart, no early WR, butterfly order unchanged.
- With HADAMARD_TIMEOUT_EN, TIMEOUT_CYC=8, dp_done never asserted → err_timeout=1 and fft_done pulse after 8 WAIT cycles, ram_wr_en never asserted, fft_busy=0.
